// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and counter-width helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    // Width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO without a pop is dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count need a known value, and
    // leaving the array unreset lets it map onto RAM instead of flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote, FWFT receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames (adds PARITY state and parity_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] dout,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = cnt_width(DIV);
    localparam int PW      = cnt_width(OVERSAMPLE);
    localparam int BW      = cnt_width(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_DEC   = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_state_t    state, state_n;
    logic           sync_a, rx_s;
    logic [DW-1:0]  div_cnt;
    logic [PW-1:0]  phase;
    logic [BW-1:0]  bit_cnt;
    logic [7:0]     shift;
    logic           tick, decide, samp0, samp1, bit_val;
    logic           par_bad, push_q;
    logic           push_evt, ferr_evt, perr_evt;
    logic           fifo_empty, fifo_full, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_a <= rx_data;
            rx_s   <= sync_a;
        end
    end

    assign busy   = (state != IDLE);
    assign tick   = busy && (div_cnt == DIV_LAST);
    assign decide = tick && (phase == PH_DEC);
    assign bit_val = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

    // Divider and bit phase sit at zero in IDLE, so each frame starts from a clean count
    // and the phase wraps on every bit boundary measured from the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (!busy) begin
            div_cnt <= '0;
            phase   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        push_evt = 1'b0;
        ferr_evt = 1'b0;
        perr_evt = 1'b0;
        unique case (state)
            IDLE:   if (!rx_s) state_n = START;
            START:  if (decide) state_n = bit_val ? IDLE : DATA;
            DATA:   if (decide && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
            PARITY: if (decide) begin
                        state_n  = STOP;
                        perr_evt = ^{shift, bit_val};
                    end
            STOP:   if (decide) begin
                        if (bit_val) begin
                            state_n  = IDLE;
                            push_evt = !par_bad;
                        end else begin
                            state_n  = BREAK;
                            ferr_evt = !par_bad;
                        end
                    end
            BREAK:  if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            par_bad   <= 1'b0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_q    <= push_evt;
            frame_err <= ferr_evt;
            if (tick && phase == PH_S0) samp0 <= rx_s;
            if (tick && phase == PH_S1) samp1 <= rx_s;
            if (state == START) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end
            if (state == DATA && decide) begin
                shift   <= {bit_val, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (perr_evt) par_bad <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_evt;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (shift),
        .pop   (pop),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=4 (64 clk/bit): byte-queue model predicts delivered bytes and error pulses.
// Define UART_RX_PARITY_EN for the 8E1 build; the parity scenario runs only then.
module tb_uart_rx;
    localparam int CLK_FREQ = 7_372_800;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int DEPTH    = 8;
    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst, rx_data, rx_ready;
    logic [7:0] dout;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .dout       (dout),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_valid = 0;
    int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_pop = 8'hxx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Compare process: every accepted byte must be the next byte the model predicted.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) begin
                n_ferr++;
                check("err_pulses_exclusive", parity_err, 0);
            end
            if (parity_err) n_perr++;
            if (overrun)    n_ovr++;
            if (rx_valid)   n_valid++;
            if (rx_valid && rx_ready) begin
                last_pop = dout;
                check("model_has_byte", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("pop_dout", dout, exp_q.pop_front());
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: decides from frame content alone what the receiver must do with it.
    task automatic predict(input logic [7:0] b, input logic par, input logic stop_b);
        logic par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = ((^b) ^ par) == 1'b0;
`else
        par_ok = 1'b1;
`endif
        if (!par_ok)                  exp_perr++;
        else if (!stop_b)             exp_ferr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                          exp_ovr++;
    endtask

    task automatic drive_bit(input logic v);
        rx_data = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_b);
        predict(b, par, stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop_b);
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        wait_clks(n);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            wait_clks(1);
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, p0;
        logic [7:0] b;

        rst = 1'b1; rx_data = 1'b1; rx_ready = 1'b1;
        wait_clks(3);
        check("rst_busy",       busy, 0);
        check("rst_rx_valid",   rx_valid, 0);
        check("rst_dout",       dout, 0);
        check("rst_frame_err",  frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overrun",    overrun, 0);
        rst = 1'b0;
        wait_clks(5);

        // 1: clean byte, consumer always ready
        v0 = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_idle("t1_busy_fall", 100);
        idle(16);
        check("t1_valid_cycles", n_valid - v0, 1);
        check("t1_byte",         last_pop, 8'hA5);
        check("t1_model_drained", exp_q.size(), 0);
        check("t1_no_frame_err", n_ferr, 0);

        // 2: 20-clock glitch on an idle line
        v0 = n_valid;
        rx_data = 1'b0;
        wait_clks(10);
        check("t2_busy_rise", busy, 1);
        wait_clks(10);
        rx_data = 1'b1;
        wait_clks(40);
        check("t2_busy_fall",  busy, 0);
        check("t2_no_valid",   n_valid - v0, 0);
        check("t2_no_frame_err", n_ferr, 0);

        // 3: stop bit 0, then line held low (break)
        v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(100);
        check("t3_busy_in_break", busy, 1);
        check("t3_frame_err_lit", n_ferr, 1);
        check("t3_frame_err_model", n_ferr, exp_ferr);
        check("t3_no_valid", n_valid - v0, 0);
        idle(2);
        wait_idle("t3_busy_after_break", 20);
        idle(16);

        // 4: nine bytes into an eight-entry FIFO with no consumer
        rx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'(i);
            send_frame(b, ^b, 1'b1);
            idle(16);
        end
        check("t4_overrun_lit",   n_ovr, 1);
        check("t4_overrun_model", n_ovr, exp_ovr);
        check("t4_rx_valid",      rx_valid, 1);
        check("t4_head",          dout, 8'h00);
        check("t4_model_depth",   exp_q.size(), 8);
        rx_ready = 1'b1;
        wait_clks(12);
        check("t4_drained",      rx_valid, 0);
        check("t4_last_byte",    last_pop, 8'h07);
        check("t4_model_empty",  exp_q.size(), 0);

        // 5: reset in data bit 4 of 0x77 with a byte waiting in the FIFO
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        idle(16);
        check("t5_pending", rx_valid, 1);
        b = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_data = b[4];
        wait_clks(32);
        f0 = n_ferr;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_busy",     busy, 0);
        check("t5_rst_rx_valid", rx_valid, 0);
        check("t5_rst_dout",     dout, 0);
        check("t5_rst_frame_err", frame_err, 0);
        rx_data = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        rx_ready = 1'b1;
        idle(10);
        v0 = n_valid;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(16);
        check("t5_byte",        last_pop, 8'h5A);
        check("t5_valid_cycles", n_valid - v0, 1);
        check("t5_no_frame_err", n_ferr - f0, 0);
        check("t5_model_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // 6: 0x01 with wrong then correct even-parity bit
        p0 = n_perr;
        f0 = n_ferr;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(16);
        check("t6_parity_err_lit", n_perr - p0, 1);
        check("t6_dropped", exp_q.size(), 0);
        send_frame(8'h01, 1'b1, 1'b1);
        idle(16);
        check("t6_byte", last_pop, 8'h01);
        check("t6_no_frame_err", n_ferr - f0, 0);
`else
        p0 = n_perr;
        check("t6_parity_err_tied", p0, 0);
`endif

        check("total_frame_err", n_ferr, exp_ferr);
        check("total_parity_err", n_perr, exp_perr);
        check("total_overrun", n_ovr, exp_ovr);
        check("total_model_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
